// File: rtl/tri_bus_arb.sv
// Round-robin arbiter and one-hot enable sequencer for a shared tri-state bus.
// Each tenure is SETUP, DRIVE..., TURN, so every handoff has two dead cycles.
module tri_bus_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         bus_en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 preempt
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  bus_en_q, bus_en_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;

  logic [OW-1:0] win_s;
  logic          any_req_s;
  logic [OW-1:0] next_ptr_s;
  logic [OW:0]   sum_v;
  logic [OW-1:0] idx_v;

  // Round-robin pick: first asserted request scanning upward from ptr, wrapping.
  always_comb begin
    win_s     = '0;
    any_req_s = 1'b0;
    sum_v     = '0;
    idx_v     = '0;
    for (int k = 0; k < N; k++) begin
      sum_v = {1'b0, ptr_q} + (OW+1)'(k);
      idx_v = (sum_v >= (OW+1)'(N)) ? OW'(sum_v - (OW+1)'(N)) : OW'(sum_v);
      if (req[idx_v] && !any_req_s) begin
        any_req_s = 1'b1;
        win_s     = idx_v;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  assign next_ptr_s = (owner_q == OW'(N-1)) ? '0 : owner_q + OW'(1);

  // Next-state and registered-output logic for the tenure sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    bus_en_d  = bus_en_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      S_IDLE, S_TURN: begin
        bus_en_d = '0;
        hold_d   = '0;
        if (any_req_s) begin
          state_d = S_SETUP;
          owner_d = win_s;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_s;
        end else begin
          state_d = S_IDLE;
          owner_d = '0;
          grant_d = '0;
        end
      end
      S_SETUP: begin
        if (req[owner_q]) begin
          state_d  = S_DRIVE;
          bus_en_d = grant_q;
          hold_d   = CW'(1);
        end else begin
          // Withdrawn before driving: no enable pulse, but the turn is still used up.
          state_d  = S_TURN;
          grant_d  = '0;
          bus_en_d = '0;
          owner_d  = '0;
          ptr_d    = next_ptr_s;
          hold_d   = '0;
        end
      end
      S_DRIVE: begin
        if (!req[owner_q] || (hold_q == CW'(MAX_HOLD))) begin
          state_d   = S_TURN;
          grant_d   = '0;
          bus_en_d  = '0;
          owner_d   = '0;
          ptr_d     = next_ptr_s;
          hold_d    = '0;
          preempt_d = req[owner_q];
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        ptr_d    = '0;
        owner_d  = '0;
        grant_d  = '0;
        bus_en_d = '0;
        hold_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      bus_en_q  <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      bus_en_q  <= bus_en_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant   = grant_q;
  assign bus_en  = bus_en_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_tri_bus_arb.sv
// Directed and random-stress bench for tri_bus_arb (N=4, MAX_HOLD=4) with
// hand-computed expectations and a per-cycle invariant monitor.
module tb_tri_bus_arb;

  localparam int N = 4;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] bus_en;
  logic [1:0]   owner;
  logic         busy;
  logic         preempt;

  int checks   = 0;
  int failures = 0;

  logic         mon_en = 1'b0;
  logic [N-1:0] grant_prev  = '0;
  logic [N-1:0] bus_en_prev = '0;

  int rot[5] = '{0, 1, 2, 3, 0};
  int wait_c[N];
  int max_wait[N];
  int run_len;
  int max_run;
  int pre_cnt;

  tri_bus_arb #(.N(N), .MAX_HOLD(M)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .grant  (grant),
    .bus_en (bus_en),
    .owner  (owner),
    .busy   (busy),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] g, input logic [N-1:0] b,
                            input logic [1:0] o, input logic bz, input logic p);
    check({tag, "_grant"},   32'(grant),   32'(g));
    check({tag, "_bus_en"},  32'(bus_en),  32'(b));
    check({tag, "_owner"},   32'(owner),   32'(o));
    check({tag, "_busy"},    32'(busy),    32'(bz));
    check({tag, "_preempt"}, 32'(preempt), 32'(p));
  endtask

  // Invariants checked every cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_onehot", ($countones(bus_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("inv_subset", ((bus_en & ~grant) == '0) ? 32'd1 : 32'd0, 32'd1);
      check("inv_grant_stable",
            ((bus_en_prev != '0) && (bus_en != '0) && (grant != grant_prev)) ? 32'd1 : 32'd0,
            32'd0);
    end
    grant_prev  <= grant;
    bus_en_prev <= bus_en;
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    expect_out("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();
    expect_out("idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request: grant one cycle after sampling, enable one cycle later.
    req = 4'b0010;
    step();
    expect_out("single_setup", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      step();
      expect_out("single_drive", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    expect_out("single_turn", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
    step();
    expect_out("single_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Rotation from a fresh reset: ptr must restart at 0 although it was 2.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("rot_setup", 4'(1 << rot[i]), 4'b0000, 2'(rot[i]), 1'b1, 1'b0);
      step();
      expect_out("rot_drive1", 4'(1 << rot[i]), 4'(1 << rot[i]), 2'(rot[i]), 1'b1, 1'b0);
      step();
      expect_out("rot_drive2", 4'(1 << rot[i]), 4'(1 << rot[i]), 2'(rot[i]), 1'b1, 1'b0);
      req[rot[i]] = 1'b0;
      step();
      expect_out("rot_turn", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
      if (i < 4) req[rot[i]] = 1'b1;
      else req = 4'b0000;
    end
    step();
    expect_out("rot_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Preemption after exactly M enable cycles; late req[1] wins the next SETUP.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b0001;
    for (int rep = 0; rep < 2; rep++) begin
      step();
      expect_out("pre_setup", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
      for (int d = 1; d <= M; d++) begin
        step();
        expect_out("pre_drive", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        if (rep == 1 && d == 2) req[1] = 1'b1;
      end
      step();
      expect_out("pre_turn", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
    end
    step();
    expect_out("pre_next", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    expect_out("pre_wd_turn", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
    step();
    expect_out("pre_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Withdraw in SETUP still advances ptr to 3.
    req = 4'b0100;
    step();
    expect_out("wd_setup", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    expect_out("wd_turn", 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
    step();
    expect_out("wd_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    step();
    expect_out("wd_next", 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0);
    step();
    expect_out("wd_drive", 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    step();
    expect_out("wd_idle2", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Short tenure of 1 leaves ptr at 2, then reset mid-DRIVE of owner 1.
    req = 4'b0010;
    step();
    step();
    req = 4'b0000;
    step();
    step();
    req = 4'b0010;
    step();
    expect_out("rm_setup", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    step();
    expect_out("rm_drive", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    expect_out("rm_reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    expect_out("rm_first", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    step();
    expect_out("rm_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Random stress: requesters hold until served, drop randomly while driving.
    for (int i = 0; i < N; i++) begin
      wait_c[i]   = 0;
      max_wait[i] = 0;
    end
    run_len = 0;
    max_run = 0;
    pre_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      if (bus_en != '0) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (preempt) pre_cnt++;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !bus_en[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
      end
      for (int i = 0; i < N; i++) begin
        if (bus_en[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
    end
    check("stress_max_run", 32'(max_run), 32'(M));
    check("stress_preempt_seen", (pre_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < N; i++) begin
      check("stress_fairness", (max_wait[i] <= N * (M + 2)) ? 32'd1 : 32'd0, 32'd1);
    end
    req = 4'b0000;
    step();
    step();
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
